// File: rtl/nn_bus_pkg.sv
//==============================================================================
// Module      : nn_bus_pkg
// Description : Shared types and constants for the RAM arbiter and its picker.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package nn_bus_pkg;

    // Arbiter states: free round-robin arbitration, or held by a locked owner
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // Requester indices
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    // One-hot vector selecting a single requester
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nn_rr_pick.sv
//==============================================================================
// Module      : nn_rr_pick
// Description : Combinational 2-way round-robin pick. Requests outside the
//               eligibility mask are ignored; on contention the requester
//               named by prio wins. Output is one-hot or zero.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module nn_rr_pick
    import nn_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eligible;

    assign eligible = req & mask;

    // Single eligible request wins outright; a tie goes to the preferred side
    always_comb begin
        gnt = eligible;
        if (eligible == 2'b11) begin
            gnt = req_onehot(prio);
        end
    end

endmodule

`default_nettype wire

// File: rtl/nn_ram_arbiter.sv
//==============================================================================
// Module      : nn_ram_arbiter
// Description : Shares one single-port word RAM between the CPU data port
//               (requester 0) and an auxiliary master (requester 1). Round-robin
//               priority, bounded lock for read-modify-write, one-cycle read
//               return and CPU stall generation.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module nn_ram_arbiter
    import nn_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic              LOCK0,
    input  logic              LOCK1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              STALL0,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t       state, state_n;
    logic             prio, prio_n;
    logic             owner, owner_n;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_n;
    logic [1:0]       rd_pend;

    logic [1:0] req;
    logic [1:0] mask;
    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       gnt_lock;
    logic       own_req;
    logic       own_lock;

    assign req  = {REQ1, REQ0};
    // While locked only the owner is eligible
    assign mask = (state == LOCKED) ? req_onehot(owner) : 2'b11;

    nn_rr_pick u_pick (
        .req  (req),
        .prio (prio),
        .mask (mask),
        .gnt  (pick_gnt)
    );

    // Grants are suppressed for as long as reset is held
    assign gnt      = RST_N ? pick_gnt : 2'b00;
    assign GNT0     = gnt[REQ_CPU];
    assign GNT1     = gnt[REQ_AUX];
    assign STALL0   = REQ0 & ~gnt[REQ_CPU];

    assign gnt_idx  = gnt[REQ_AUX];
    assign gnt_lock = gnt[REQ_AUX] ? LOCK1 : LOCK0;
    assign own_req  = owner ? REQ1 : REQ0;
    assign own_lock = owner ? LOCK1 : LOCK0;

    // Read return: pending strobe from the previous grant, data straight from RAM
    assign RVALID0  = rd_pend[REQ_CPU] & RST_N;
    assign RVALID1  = rd_pend[REQ_AUX] & RST_N;
    assign RDATA0   = RAM_RDATA;
    assign RDATA1   = RAM_RDATA;

    // Next-state logic for arbitration state, priority, owner and lock counter
    always_comb begin
        state_n    = state;
        prio_n     = prio;
        owner_n    = owner;
        lock_cnt_n = lock_cnt;
        case (state)
            ARB: begin
                if (|gnt) begin
                    prio_n = ~gnt_idx;
                    if (gnt_lock) begin
                        state_n    = LOCKED;
                        owner_n    = gnt_idx;
                        lock_cnt_n = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Priority always leaves pointing away from the owner
                prio_n = ~owner;
                if (own_req && own_lock && (int'(lock_cnt) + 1 < MAX_LOCK)) begin
                    lock_cnt_n = lock_cnt + CNT_W'(1);
                end else begin
                    // Owner released, went idle or used up its budget; this
                    // cycle's grant (if any) is still served
                    state_n    = ARB;
                    lock_cnt_n = '0;
                end
            end
            default: begin
                state_n    = ARB;
                lock_cnt_n = '0;
            end
        endcase
    end

    // State, priority and read-pending registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ARB;
            prio     <= 1'b0;
            owner    <= 1'b0;
            lock_cnt <= '0;
            rd_pend  <= 2'b00;
        end else begin
            state    <= state_n;
            prio     <= prio_n;
            owner    <= owner_n;
            lock_cnt <= lock_cnt_n;
            rd_pend  <= gnt & ~{WE1, WE0};
        end
    end

    // RAM port mux from the granted requester; all zero when nobody is granted
    always_comb begin
        RAM_EN    = |gnt;
        RAM_WE    = 1'b0;
        RAM_ADDR  = '0;
        RAM_WDATA = '0;
        if (gnt[REQ_CPU]) begin
            RAM_WE    = WE0;
            RAM_ADDR  = ADDR0;
            RAM_WDATA = WDATA0;
        end else if (gnt[REQ_AUX]) begin
            RAM_WE    = WE1;
            RAM_ADDR  = ADDR1;
            RAM_WDATA = WDATA1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nn_ram_arbiter.sv
//==============================================================================
// Module      : tb_nn_ram_arbiter
// Description : Directed self-checking bench for nn_ram_arbiter with a
//               behavioural single-port RAM (one-cycle read latency).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nn_ram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
    logic [ADDR_W-1:0] ADDR0, ADDR1;
    logic [DATA_W-1:0] WDATA0, WDATA1;
    logic              GNT0, GNT1, STALL0, RVALID0, RVALID1;
    logic [DATA_W-1:0] RDATA0, RDATA1;
    logic              RAM_EN, RAM_WE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_WDATA;
    logic [DATA_W-1:0] RAM_RDATA;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    nn_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .LOCK0(LOCK0), .LOCK1(LOCK1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .STALL0(STALL0),
        .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    // Single-port RAM model, preloaded on the first edge
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              loaded = 1'b0;
    always @(posedge CLK) begin
        if (!loaded) begin
            mem[5] <= 32'h0000_00A5;
            mem[9] <= 32'h0000_0099;
            loaded <= 1'b1;
        end else if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
            else        RAM_RDATA     <= mem[RAM_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; WE1 = 1'b0;
        LOCK0 = 1'b0; LOCK1 = 1'b0; ADDR0 = 10'd5; ADDR1 = 10'd9;
        WDATA0 = '0; WDATA1 = '0;

        // Reset held three cycles with both requesting
        for (int i = 0; i < 3; i++) begin
            cyc(); #3;
            chk("rst_gnt0", GNT0, 0);
            chk("rst_gnt1", GNT1, 0);
            chk("rst_ram_en", RAM_EN, 0);
            chk("rst_rvalid0", RVALID0, 0);
            chk("rst_rvalid1", RVALID1, 0);
        end

        // Release: prio=0, so requester 0 first, then alternation
        cyc(); RST_N = 1'b1; #3;
        chk("c3_gnt0", GNT0, 1); chk("c3_gnt1", GNT1, 0); chk("c3_stall0", STALL0, 0);
        chk("c3_ram_addr", RAM_ADDR, 5); chk("c3_ram_en", RAM_EN, 1);
        cyc(); #3;
        chk("c4_gnt0", GNT0, 0); chk("c4_gnt1", GNT1, 1); chk("c4_stall0", STALL0, 1);
        chk("c4_rvalid0", RVALID0, 1); chk("c4_rdata0", RDATA0, 32'hA5);
        cyc(); #3;
        chk("c5_gnt0", GNT0, 1); chk("c5_gnt1", GNT1, 0); chk("c5_stall0", STALL0, 0);
        chk("c5_rvalid1", RVALID1, 1); chk("c5_rdata1", RDATA1, 32'h99);
        chk("c5_rvalid0", RVALID0, 0);
        cyc(); #3;
        chk("c6_gnt1", GNT1, 1); chk("c6_stall0", STALL0, 1);
        chk("c6_rvalid0", RVALID0, 1); chk("c6_rdata0", RDATA0, 32'hA5);

        // Idle: RAM port all zero
        cyc(); REQ0 = 1'b0; REQ1 = 1'b0; #3;
        chk("idle_gnt0", GNT0, 0); chk("idle_gnt1", GNT1, 0);
        chk("idle_ram_en", RAM_EN, 0); chk("idle_ram_addr", RAM_ADDR, 0);
        chk("idle_rvalid1", RVALID1, 1); chk("idle_rdata1", RDATA1, 32'h99);

        // Write then read back
        cyc(); REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 10'd3; WDATA0 = 32'hDEAD_BEEF; #3;
        chk("wr_gnt0", GNT0, 1); chk("wr_ram_we", RAM_WE, 1);
        chk("wr_ram_addr", RAM_ADDR, 3); chk("wr_ram_wdata", RAM_WDATA, 32'hDEAD_BEEF);
        cyc(); WE0 = 1'b0; #3;
        chk("rd_gnt0", GNT0, 1); chk("rd_ram_we", RAM_WE, 0);
        chk("wr_no_rvalid0", RVALID0, 0);
        cyc(); REQ0 = 1'b0; #3;
        chk("rb_rvalid0", RVALID0, 1); chk("rb_rdata0", RDATA0, 32'hDEAD_BEEF);

        // Lock bound: prio=1 now, requester 1 locks, requester 0 waits 4 cycles
        cyc(); REQ0 = 1'b1; ADDR0 = 10'd5; REQ1 = 1'b1; LOCK1 = 1'b1; #3;
        chk("lk1_gnt1", GNT1, 1); chk("lk1_stall0", STALL0, 1);
        for (int i = 2; i <= 4; i++) begin
            cyc(); #3;
            chk("lk_gnt1", GNT1, 1); chk("lk_gnt0", GNT0, 0); chk("lk_stall0", STALL0, 1);
        end
        cyc(); #3;
        chk("lk5_gnt0", GNT0, 1); chk("lk5_gnt1", GNT1, 0); chk("lk5_stall0", STALL0, 0);

        // Early unlock: lock one grant, drop LOCK1 on the second
        cyc(); #3;
        chk("eu1_gnt1", GNT1, 1); chk("eu1_gnt0", GNT0, 0);
        cyc(); LOCK1 = 1'b0; #3;
        chk("eu2_gnt1", GNT1, 1); chk("eu2_gnt0", GNT0, 0);
        cyc(); #3;
        chk("eu3_gnt0", GNT0, 1); chk("eu3_gnt1", GNT1, 0);

        // Idle, collect the last read of requester 0
        cyc(); REQ0 = 1'b0; REQ1 = 1'b0; #3;
        chk("eu_rvalid0", RVALID0, 1); chk("eu_rdata0", RDATA0, 32'hA5);

        // Reset mid-read: requester 1 read granted, reset in the next cycle
        cyc(); REQ1 = 1'b1; #3;
        chk("mr_gnt1", GNT1, 1);
        cyc(); RST_N = 1'b0; REQ1 = 1'b0; #3;
        chk("mr_rvalid1_rst", RVALID1, 0); chk("mr_gnt1_rst", GNT1, 0);
        cyc(); RST_N = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; #3;
        chk("mr_rvalid1_after", RVALID1, 0);
        chk("mr_gnt0", GNT0, 1); chk("mr_gnt1", GNT1, 0);

        // Idle; prio now 1
        cyc(); REQ0 = 1'b0; REQ1 = 1'b0; #3;
        chk("mr_rvalid0", RVALID0, 1); chk("mr_rvalid1_idle", RVALID1, 0);

        // Read by 0 vs write by 1 with prio=1: write first, then the read sees it
        cyc(); REQ0 = 1'b1; ADDR0 = 10'd9;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 10'd9; WDATA1 = 32'h1234_5678; #3;
        chk("rw_gnt1", GNT1, 1); chk("rw_gnt0", GNT0, 0); chk("rw_ram_we", RAM_WE, 1);
        cyc(); REQ1 = 1'b0; WE1 = 1'b0; #3;
        chk("rw_gnt0_next", GNT0, 1); chk("rw_rvalid1", RVALID1, 0);
        cyc(); REQ0 = 1'b0; #3;
        chk("rw_rvalid0", RVALID0, 1); chk("rw_rdata0", RDATA0, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
